// File: rtl/yarp_pkg.sv
// Shared YARP core types: fetch buffer entry, fetch control state and PC helpers.
package yarp_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/yarp_fetch_if.sv
// Instruction-memory req/gnt/rvalid handshake between the fetch unit and memory.
interface yarp_fetch_if;

    logic        instr_mem_req_o;
    logic [31:0] instr_mem_addr_o;
    logic        instr_mem_gnt_i;
    logic        instr_mem_rvalid_i;
    logic [31:0] instr_mem_rd_data_i;

    modport master (
        output instr_mem_req_o,
        output instr_mem_addr_o,
        input  instr_mem_gnt_i,
        input  instr_mem_rvalid_i,
        input  instr_mem_rd_data_i
    );

    modport slave (
        input  instr_mem_req_o,
        input  instr_mem_addr_o,
        output instr_mem_gnt_i,
        output instr_mem_rvalid_i,
        output instr_mem_rd_data_i
    );

endinterface

// File: rtl/yarp_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries with flush.
// Push while full is accepted only when a pop happens in the same cycle.
module yarp_fetch_fifo
    import yarp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_push,
    input  fetch_entry_t                      i_data,
    input  logic                              i_pop,
    input  logic                              i_flush,
    output fetch_entry_t                      o_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
    output logic                              o_empty,
    output logic                              o_full
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_entry_t    r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy tracking; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/yarp_fetch.sv
// YARP instruction-fetch unit: owns the fetch PC, keeps up to MAX_OUTSTANDING
// requests in flight, buffers responses with their PCs and squashes responses
// that were requested before a redirect.
// Optional macro YARP_FETCH_BYPASS_EN: forward a response straight to decode
// when the buffer is empty (one cycle less latency, combinational output path).
module yarp_fetch
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    yarp_fetch_if.master                      mem,
    input  logic                              redirect_i,
    input  logic [31:0]                       redirect_pc_i,
    output logic                              instr_valid_o,
    output logic [31:0]                       instr_o,
    output logic [31:0]                       instr_pc_o,
    input  logic                              instr_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e   r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_resp_pc;
    logic [OW-1:0]  r_outstanding;
    logic [OW-1:0]  r_discard;

    logic           w_req;
    logic           w_hs;
    logic           w_rsp;
    logic           w_drop;
    logic           w_accept;
    logic           w_bypass;
    logic           w_push;
    logic           w_pop;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic [CW-1:0]  w_count;
    logic [31:0]    w_in_flight;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;

    // Never request more than the buffer can absorb once everything returns.
    assign w_in_flight = 32'(r_outstanding) + 32'(w_count);
    assign w_req       = (r_state == FETCH_RUN)
                      && (32'(r_outstanding) < MAX_OUTSTANDING)
                      && (w_in_flight < FIFO_DEPTH)
                      && !redirect_i;

    assign mem.instr_mem_req_o  = w_req;
    assign mem.instr_mem_addr_o = (r_state == FETCH_RUN) ? r_fetch_pc : '0;

    assign w_hs     = w_req && mem.instr_mem_gnt_i;
    assign w_rsp    = mem.instr_mem_rvalid_i && (r_outstanding != '0);
    assign w_drop   = w_rsp && (r_discard != '0);
    assign w_accept = w_rsp && (r_discard == '0);

`ifdef YARP_FETCH_BYPASS_EN
    assign w_bypass = w_accept && w_fifo_empty && !redirect_i;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed response consumed by decode this cycle is not stored.
    assign w_push = w_accept && !redirect_i && !(w_bypass && instr_ready_i);
    assign w_pop  = !w_fifo_empty && instr_ready_i;

    assign w_push_entry.pc    = r_resp_pc;
    assign w_push_entry.instr = mem.instr_mem_rd_data_i;

    assign instr_valid_o = !w_fifo_empty || w_bypass;
    assign instr_o       = !w_fifo_empty ? w_head.instr
                         : (w_bypass ? mem.instr_mem_rd_data_i : '0);
    assign instr_pc_o    = !w_fifo_empty ? w_head.pc
                         : (w_bypass ? r_resp_pc : '0);
    assign fifo_count_o  = w_count;

    yarp_fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Fetch/response PC, in-flight and squash bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= FETCH_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= FETCH_RUN;
            r_outstanding <= r_outstanding + OW'(w_hs) - OW'(w_rsp);
            if (redirect_i) begin
                r_fetch_pc <= align_pc(redirect_pc_i);
                r_resp_pc  <= align_pc(redirect_pc_i);
                // Everything still in flight after this cycle's response is stale.
                r_discard  <= r_outstanding - OW'(w_rsp);
            end else begin
                if (w_hs)     r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
                if (w_accept) r_resp_pc  <= r_resp_pc + 32'(INSTR_BYTES);
                r_discard <= r_discard - OW'(w_drop);
            end
        end
    end

    // Protocol sanity: no stray responses, no buffer overflow.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(mem.instr_mem_rvalid_i && (r_outstanding == '0)))
                else $error("yarp_fetch: rvalid with no outstanding request");
            assert (!(w_push && w_fifo_full && !w_pop))
                else $error("yarp_fetch: prefetch buffer overflow");
        end
    end

endmodule

// File: tb/tb_yarp_fetch.sv
// Testbench for yarp_fetch: memory model, in-order scoreboard and directed steps.
module tb_yarp_fetch;
    import yarp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_ready_i;
    logic        instr_valid_o, instr_valid2;
    logic [31:0] instr_o, instr_pc_o, instr2, instr_pc2;
    logic [2:0]  fifo_count_o, fifo_count2;

    always #5 clk = ~clk;

    yarp_fetch_if mif ();
    yarp_fetch_if mif2 ();

    assign mif2.instr_mem_gnt_i     = mif.instr_mem_gnt_i;
    assign mif2.instr_mem_rvalid_i  = mif.instr_mem_rvalid_i;
    assign mif2.instr_mem_rd_data_i = mif.instr_mem_rd_data_i;

    yarp_fetch dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem           (mif),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .fifo_count_o  (fifo_count_o)
    );

    // Shadow instance checking the address wrap at the top of memory.
    yarp_fetch #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem           (mif2),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid2),
        .instr_o       (instr2),
        .instr_pc_o    (instr_pc2),
        .instr_ready_i (instr_ready_i),
        .fifo_count_o  (fifo_count2)
    );

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    int unsigned  n_grants = 0;
    logic [31:0]  resp_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  model_pc;
    bit           gnt_en, rsp_en, ready, redir;
    logic [31:0]  redir_pc;
    logic         s_req, s_valid;
    logic [31:0]  s_addr, s_pc, s_instr, s2_addr, s2_pc;
    logic [2:0]   s_count;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample mid-cycle, update model and scoreboard.
    task automatic tick();
        fetch_entry_t e;
        mif.instr_mem_gnt_i = gnt_en;
        if (rsp_en && resp_q.size() > 0) begin
            mif.instr_mem_rvalid_i  = 1'b1;
            mif.instr_mem_rd_data_i = mem_data(resp_q[0]);
        end else begin
            mif.instr_mem_rvalid_i  = 1'b0;
            mif.instr_mem_rd_data_i = '0;
        end
        instr_ready_i = ready;
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        @(negedge clk);
        s_req   = mif.instr_mem_req_o;
        s_addr  = mif.instr_mem_addr_o;
        s_valid = instr_valid_o;
        s_pc    = instr_pc_o;
        s_instr = instr_o;
        s_count = fifo_count_o;
        s2_addr = mif2.instr_mem_addr_o;
        s2_pc   = instr_pc2;
        if (reset_n) begin
            if (redir) chk("redirect_no_req", 32'(s_req), 32'd0);
            if (s_req && mif.instr_mem_gnt_i) begin
                chk("grant_addr", s_addr, model_pc);
                resp_q.push_back(s_addr);
                e.pc    = model_pc;
                e.instr = mem_data(model_pc);
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
                n_grants++;
            end
            if (mif.instr_mem_rvalid_i) void'(resp_q.pop_front());
            if (s_valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", s_pc, e.pc);
                    chk("sb_instr", s_instr, e.instr);
                end
            end
            if (redir) begin
                exp_q.delete();
                model_pc = {redir_pc[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles (memory reset alongside), then cycle 0 with reset released.
    task automatic do_reset();
        resp_q.delete();
        exp_q.delete();
        redir   = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        model_pc = 32'h1000;
        reset_n  = 1'b1;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        gnt_en = 1'b0; rsp_en = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = '0;
        model_pc = 32'h1000;

        // Reset state
        tick();
        tick();
        chk("rst_req",   32'(s_req),   32'd0);
        chk("rst_addr",  s_addr,       32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_instr", s_instr,      32'd0);
        chk("rst_pc",    s_pc,         32'd0);
        chk("rst_count", 32'(s_count), 32'd0);

        // Streaming fetch, first request one cycle after release
        gnt_en = 1'b1; rsp_en = 1'b1; ready = 1'b1; reset_n = 1'b1;
        tick();
        chk("t1_c0_req", 32'(s_req), 32'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("t1_req",       32'(s_req), 32'd1);
            chk("t1_addr",      s_addr,  32'h1000 + 32'(4 * i));
            chk("t1_wrap_addr", s2_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            if (i == 2) begin
                chk("t1_first_valid", 32'(s_valid), 32'd1);
                chk("t1_first_pc",    s_pc,  32'h1000);
                chk("t5_wrap_pc0",    s2_pc, 32'hFFFF_FFF8);
            end else begin
                chk("t1_valid_early", 32'(s_valid), 32'd0);
            end
        end
        tick();
        chk("t5_wrap_pc1", s2_pc, 32'hFFFF_FFFC);
        tick();
        chk("t5_wrap_pc2", s2_pc, 32'h0000_0000);
        repeat (8) tick();

        // Back-pressure fills the buffer and stops requests
        ready = 1'b0;
        do_reset();
        n_grants = 0;
        repeat (10) tick();
        chk("t2_count",    32'(s_count), 32'd4);
        chk("t2_req_low",  32'(s_req),   32'd0);
        chk("t2_grants",   n_grants,     32'd4);
        ready = 1'b1;
        tick();
        chk("t2_first_pop_pc", s_pc, 32'h1000);
        tick();
        chk("t2_resume_req",  32'(s_req), 32'd1);
        chk("t2_resume_addr", s_addr, 32'h1010);
        repeat (6) tick();

        // Grant stall holds request and address
        do_reset();
        tick();
        tick();
        gnt_en = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_req",  32'(s_req), 32'd1);
            chk("t4_stall_addr", s_addr, 32'h1008);
        end
        gnt_en = 1'b1;
        tick();
        tick();
        chk("t4_next_req",  32'(s_req), 32'd1);
        chk("t4_next_addr", s_addr, 32'h100C);
        repeat (4) tick();

        // Redirect with two stale requests in flight, one returning that cycle
        do_reset();
        tick();
        tick();
        tick();
        rsp_en = 1'b0;
        tick();
        redir = 1'b1; redir_pc = 32'h2002; rsp_en = 1'b1;
        tick();
        redir = 1'b0;
        tick();
        chk("t3_new_addr",  s_addr, 32'h2000);
        chk("t3_new_req",   32'(s_req),   32'd1);
        chk("t3_flushed",   32'(s_count), 32'd0);
        chk("t3_no_valid",  32'(s_valid), 32'd0);
        tick();
        tick();
        chk("t3_first_valid", 32'(s_valid), 32'd1);
        chk("t3_first_pc",    s_pc, 32'h2000);
        repeat (5) tick();

        // Reset in the middle of traffic
        ready = 1'b0;
        do_reset();
        repeat (4) tick();
        rsp_en  = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("t6_pre_count", 32'(s_count), 32'd3);
        resp_q.delete();
        exp_q.delete();
        tick();
        chk("t6_req",   32'(s_req),   32'd0);
        chk("t6_valid", 32'(s_valid), 32'd0);
        chk("t6_count", 32'(s_count), 32'd0);
        model_pc = 32'h1000;
        reset_n = 1'b1; ready = 1'b1; rsp_en = 1'b1;
        tick();
        tick();
        chk("t6_restart_req",  32'(s_req), 32'd1);
        chk("t6_restart_addr", s_addr, 32'h1000);
        repeat (6) tick();

        // Randomised traffic against the scoreboard
        for (int unsigned i = 0; i < 400; i++) begin
            gnt_en   = ($urandom_range(0, 3) != 0);
            rsp_en   = ($urandom_range(0, 3) != 0);
            ready    = ($urandom_range(0, 2) != 0);
            redir    = ($urandom_range(0, 19) == 0);
            redir_pc = $urandom;
            tick();
        end
        redir = 1'b0; gnt_en = 1'b0; rsp_en = 1'b1; ready = 1'b1;
        repeat (10) tick();
        chk("drain_sb_empty",  32'(exp_q.size()),  32'd0);
        chk("drain_mem_empty", 32'(resp_q.size()), 32'd0);
        chk("drain_valid",     32'(s_valid),       32'd0);
        chk("drain_count",     32'(s_count),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yarp_fetch.md
Name: yarp_fetch

Overview:
Parametrised instruction-fetch unit for the next-generation YARP core. It replaces the single-cycle PC register and its combinational instruction-memory path. The block owns the fetch PC and issues requests over a req/gnt/rvalid memory handshake with multiple outstanding requests. Returned instructions are buffered with their PCs in a prefetch FIFO, and the block accepts PC redirects (branch/jump) from execute with stale-response squashing.

Parameters:
RESET_PC, 32'h1000, first fetch address after reset
FIFO_DEPTH, 4, prefetch buffer entries; power of 2, >=2
MAX_OUTSTANDING, 2, max granted-but-unreturned requests; 1..FIFO_DEPTH

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
instr_mem_req_o  out  1  fetch request valid
instr_mem_addr_o  out  32  fetch address, word aligned
instr_mem_gnt_i  in  1  memory accepts request this cycle
instr_mem_rvalid_i  in  1  read data valid; in-order, one per grant
instr_mem_rd_data_i  in  32  read data
redirect_i  in  1  redirect fetch stream
redirect_pc_i  in  32  redirect target; bits [1:0] ignored
instr_valid_o  out  1  instruction available to decode
instr_o  out  32  instruction
instr_pc_o  out  32  PC of instr_o
instr_ready_i  in  1  decode consumes instruction
fifo_count_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (reset_n low at posedge):
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0; started = 0.
  - All outputs 0.
- started sets on the first posedge with reset_n high. instr_mem_req_o is low until started is set, so the first request appears one cycle after reset release.
- Request:
  - instr_mem_req_o = started && outstanding < MAX_OUTSTANDING && (outstanding + fifo_count) < FIFO_DEPTH && !redirect_i.
  - instr_mem_addr_o = fetch_pc.
  - Handshake occurs on req && gnt. Then fetch_pc += 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0).
  - While req is high and gnt is low, addr stays stable and req stays asserted unless capacity changes it.
- Outstanding count: outstanding_next = outstanding + (req&&gnt) - rvalid.
- Response: rvalid arrives at earliest the cycle after its grant.
  - If discard > 0: the response is dropped and discard decrements.
  - Otherwise {resp_pc, rd_data} is pushed to the FIFO and resp_pc += 4.
  - rvalid while outstanding == 0 is ignored (assertion fires).
- Output:
  - instr_valid_o = FIFO not empty; instr_o / instr_pc_o come from the FIFO head.
  - Pop on valid && ready.
  - Push and pop in the same cycle are legal at any occupancy.
  - Overflow is impossible by request gating (assertion).
- Redirect (redirect_i high):
  - FIFO flushed.
  - fetch_pc and resp_pc set to {redirect_pc_i[31:2], 2'b00}.
  - discard = outstanding + 0 - (rvalid && discard==0 ? 1 : 0) + discard-adjusted count. Equivalently: every request granted before the redirect cycle whose response has not yet arrived is discarded, including one returning in the redirect cycle.
  - No request is issued in the redirect cycle. The new address is driven from the next cycle.
  - instr_valid_o is 0 from the cycle after the redirect until the first post-redirect response is pushed.
- Latency without bypass: gnt in cycle N, earliest rvalid N+1, instr_valid_o N+2.
- Reset mid-operation clears all state. The memory is required to be reset concurrently.

Optional Feature:
YARP_FETCH_BYPASS_EN
- Defined:
  - When the FIFO is empty, discard == 0 and rvalid is high, the response drives instr_o / instr_pc_o / instr_valid_o combinationally in the same cycle.
  - The entry is pushed only if instr_ready_i is low.
  - Latency becomes gnt N -> valid N+1.
- Undefined: all outputs come from FIFO registers, giving a registered output path.

Decomposition:
- yarp_pkg gains:
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
  - constant INSTR_BYTES = 4
- One natural sub-module: yarp_fetch_fifo, a synchronous FIFO parametrised on FIFO_DEPTH, storing fetch_entry_t, with push, pop, flush, count, empty and full.

Test Plan:
1. gnt=1, rvalid one cycle after gnt, ready=1 -> addrs 0x1000, 0x1004, 0x1008 on consecutive cycles from cycle 1; first instr_valid_o at cycle 3 with instr_pc_o=0x1000.
2. ready=0 for 10 cycles -> fifo_count_o reaches 4 and req_o drops with no extra grants; ready=1 -> pops in order 0x1000..0x100C and fetch resumes at 0x1010.
3. Two outstanding (0x1008, 0x100C), redirect_pc_i=0x2002 -> next addr 0x2000; both stale responses dropped; first valid instr_pc_o=0x2000.
4. gnt=0 for 5 cycles at addr 0x1008 -> req_o stays 1 and addr stays 0x1008; after gnt, next addr is 0x100C.
5. RESET_PC=0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; output PCs match.
6. Reset asserted with 2 outstanding and 3 FIFO entries -> next cycle: req_o=0, instr_valid_o=0, fifo_count_o=0; after release, fetch restarts at 0x1000.
